// File: rtl/ftdi_pkg.sv
// Shared types and constants for the FT2232H port arbiter and fifo_interface.
// Defines the arbiter state encoding, requester IDs and the byte width.
package ftdi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_TX_WAIT = 2'd1,
        ARB_RX_WAIT = 2'd2
    } arb_state_t;

    typedef logic req_id_t;
    localparam req_id_t REQ_TX = 1'b0;
    localparam req_id_t REQ_RX = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/ftdi_port_arbiter_if.sv
// Bundle of requester handshakes and fifo_interface strobes seen by the arbiter.
// master = the arbiter; slave = the requesters plus fifo_interface.
interface ftdi_port_arbiter_if;
    import ftdi_pkg::*;

    logic              tx_req_i;
    logic [BYTE_W-1:0] tx_data_i;
    logic              tx_gnt_o;
    logic              tx_done_o;
    logic              tx_err_o;
    logic              rx_req_i;
    logic              rx_gnt_o;
    logic              rx_done_o;
    logic [BYTE_W-1:0] rx_data_o;
    logic              rx_err_o;
    logic              fifo_tx_data_rdy_o;
    logic [BYTE_W-1:0] fifo_tx_data_o;
    logic              fifo_tx_ok_i;
    logic              fifo_tx_err_i;
    logic              fifo_rx_poll_o;
    logic              fifo_rx_data_rdy_i;
    logic              fifo_rx_err_i;
    logic [BYTE_W-1:0] fifo_rx_data_i;
    logic              fifo_busy_i;
    logic              timeout_o;

    modport master (
        input  tx_req_i, tx_data_i, rx_req_i,
        input  fifo_tx_ok_i, fifo_tx_err_i, fifo_rx_data_rdy_i, fifo_rx_err_i,
        input  fifo_rx_data_i, fifo_busy_i,
        output tx_gnt_o, tx_done_o, tx_err_o,
        output rx_gnt_o, rx_done_o, rx_data_o, rx_err_o,
        output fifo_tx_data_rdy_o, fifo_tx_data_o, fifo_rx_poll_o, timeout_o
    );

    modport slave (
        output tx_req_i, tx_data_i, rx_req_i,
        output fifo_tx_ok_i, fifo_tx_err_i, fifo_rx_data_rdy_i, fifo_rx_err_i,
        output fifo_rx_data_i, fifo_busy_i,
        input  tx_gnt_o, tx_done_o, tx_err_o,
        input  rx_gnt_o, rx_done_o, rx_data_o, rx_err_o,
        input  fifo_tx_data_rdy_o, fifo_tx_data_o, fifo_rx_poll_o, timeout_o
    );

endinterface

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYCLES-1.
module arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wd_cnt;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wd_cnt <= '0;
        end else if (clear_i) begin
            r_wd_cnt <= '0;
        end else if (enable_i) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end
    end

    assign expired_o = enable_i && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ftdi_port_arbiter.sv
// Round-robin arbiter with burst hold sharing the FT2232H byte port between TX and RX.
// Define FTDI_ARB_STATS_EN to add saturating error/timeout counters.
module ftdi_port_arbiter
    import ftdi_pkg::*;
#(
    parameter int BURST_LEN      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                clk_i,
    input  logic                reset_i,
    ftdi_port_arbiter_if.master bus
`ifdef FTDI_ARB_STATS_EN
    ,
    output logic [15:0]         tx_err_cnt_o,
    output logic [15:0]         rx_err_cnt_o,
    output logic [15:0]         timeout_cnt_o
`endif
);
    localparam int BURST_W = $clog2(BURST_LEN + 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(BURST_LEN);

    arb_state_t         r_state, w_state_next;
    req_id_t            r_last, w_last_next, w_pick;
    logic [BURST_W-1:0] r_burst, w_burst_next;

    logic              r_tx_gnt, w_tx_gnt_next;
    logic              r_tx_done, w_tx_done_next;
    logic              r_tx_err, w_tx_err_next;
    logic              r_rx_gnt, w_rx_gnt_next;
    logic              r_rx_done, w_rx_done_next;
    logic              r_rx_err, w_rx_err_next;
    logic              r_strobe, w_strobe_next;
    logic              r_poll, w_poll_next;
    logic              r_timeout, w_timeout_next;
    logic [BYTE_W-1:0] r_fifo_tx_data, w_fifo_tx_data_next;
    logic [BYTE_W-1:0] r_rx_data, w_rx_data_next;

    logic w_wd_clear, w_wd_enable, w_wd_expired;

    assign w_wd_clear  = (r_state == ARB_IDLE);
    assign w_wd_enable = (r_state != ARB_IDLE);

    arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (w_wd_clear),
        .enable_i  (w_wd_enable),
        .expired_o (w_wd_expired)
    );

    always_comb begin
        w_state_next        = r_state;
        w_last_next         = r_last;
        w_burst_next        = r_burst;
        w_pick              = REQ_TX;
        w_tx_gnt_next       = 1'b0;
        w_tx_done_next      = 1'b0;
        w_tx_err_next       = 1'b0;
        w_rx_gnt_next       = 1'b0;
        w_rx_done_next      = 1'b0;
        w_rx_err_next       = 1'b0;
        w_strobe_next       = 1'b0;
        w_poll_next         = 1'b0;
        w_timeout_next      = 1'b0;
        w_fifo_tx_data_next = r_fifo_tx_data;
        w_rx_data_next      = r_rx_data;

        case (r_state)
            ARB_IDLE: begin
                if (!bus.fifo_busy_i && (bus.tx_req_i || bus.rx_req_i)) begin
                    // burst count 0 means nobody served yet, so a first tie goes to TX
                    if (!bus.rx_req_i)
                        w_pick = REQ_TX;
                    else if (!bus.tx_req_i)
                        w_pick = REQ_RX;
                    else if (r_burst != '0 && r_burst < BURST_MAX)
                        w_pick = r_last;
                    else
                        w_pick = other_req(r_last);

                    if (r_burst != '0 && w_pick == r_last)
                        w_burst_next = (r_burst == BURST_MAX) ? r_burst : r_burst + BURST_W'(1);
                    else
                        w_burst_next = BURST_W'(1);
                    w_last_next = w_pick;

                    if (w_pick == REQ_TX) begin
                        w_tx_gnt_next       = 1'b1;
                        w_strobe_next       = 1'b1;
                        w_fifo_tx_data_next = bus.tx_data_i;
                        w_state_next        = ARB_TX_WAIT;
                    end else begin
                        w_rx_gnt_next = 1'b1;
                        w_poll_next   = 1'b1;
                        w_state_next  = ARB_RX_WAIT;
                    end
                end
            end
            ARB_TX_WAIT: begin
                if (bus.fifo_tx_err_i) begin
                    w_tx_err_next = 1'b1;
                    w_state_next  = ARB_IDLE;
                end else if (bus.fifo_tx_ok_i) begin
                    w_tx_done_next = 1'b1;
                    w_state_next   = ARB_IDLE;
                end else if (w_wd_expired) begin
                    w_tx_err_next  = 1'b1;
                    w_timeout_next = 1'b1;
                    w_state_next   = ARB_IDLE;
                end
            end
            ARB_RX_WAIT: begin
                if (bus.fifo_rx_err_i) begin
                    w_rx_err_next = 1'b1;
                    w_state_next  = ARB_IDLE;
                end else if (bus.fifo_rx_data_rdy_i) begin
                    w_rx_done_next = 1'b1;
                    w_rx_data_next = bus.fifo_rx_data_i;
                    w_state_next   = ARB_IDLE;
                end else if (w_wd_expired) begin
                    w_rx_err_next  = 1'b1;
                    w_timeout_next = 1'b1;
                    w_state_next   = ARB_IDLE;
                end
            end
            default: w_state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state        <= ARB_IDLE;
            r_last         <= REQ_RX;
            r_burst        <= '0;
            r_tx_gnt       <= 1'b0;
            r_tx_done      <= 1'b0;
            r_tx_err       <= 1'b0;
            r_rx_gnt       <= 1'b0;
            r_rx_done      <= 1'b0;
            r_rx_err       <= 1'b0;
            r_strobe       <= 1'b0;
            r_poll         <= 1'b0;
            r_timeout      <= 1'b0;
            r_fifo_tx_data <= '0;
            r_rx_data      <= '0;
        end else begin
            r_state        <= w_state_next;
            r_last         <= w_last_next;
            r_burst        <= w_burst_next;
            r_tx_gnt       <= w_tx_gnt_next;
            r_tx_done      <= w_tx_done_next;
            r_tx_err       <= w_tx_err_next;
            r_rx_gnt       <= w_rx_gnt_next;
            r_rx_done      <= w_rx_done_next;
            r_rx_err       <= w_rx_err_next;
            r_strobe       <= w_strobe_next;
            r_poll         <= w_poll_next;
            r_timeout      <= w_timeout_next;
            r_fifo_tx_data <= w_fifo_tx_data_next;
            r_rx_data      <= w_rx_data_next;
        end
    end

    assign bus.tx_gnt_o           = r_tx_gnt;
    assign bus.tx_done_o          = r_tx_done;
    assign bus.tx_err_o           = r_tx_err;
    assign bus.rx_gnt_o           = r_rx_gnt;
    assign bus.rx_done_o          = r_rx_done;
    assign bus.rx_err_o           = r_rx_err;
    assign bus.rx_data_o          = r_rx_data;
    assign bus.fifo_tx_data_rdy_o = r_strobe;
    assign bus.fifo_tx_data_o     = r_fifo_tx_data;
    assign bus.fifo_rx_poll_o     = r_poll;
    assign bus.timeout_o          = r_timeout;

`ifdef FTDI_ARB_STATS_EN
    logic [15:0] r_tx_err_cnt, r_rx_err_cnt, r_timeout_cnt;

    // Counters advance on the same edge that registers the matching pulse.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_tx_err_cnt  <= '0;
            r_rx_err_cnt  <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (w_tx_err_next)  r_tx_err_cnt  <= sat_inc16(r_tx_err_cnt);
            if (w_rx_err_next)  r_rx_err_cnt  <= sat_inc16(r_rx_err_cnt);
            if (w_timeout_next) r_timeout_cnt <= sat_inc16(r_timeout_cnt);
        end
    end

    assign tx_err_cnt_o  = r_tx_err_cnt;
    assign rx_err_cnt_o  = r_rx_err_cnt;
    assign timeout_cnt_o = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_ftdi_port_arbiter.sv
// Self-checking bench for ftdi_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a transaction-level model.
module tb_ftdi_port_arbiter;
    localparam int BURST = 2;
    localparam int TMO   = 16;

    logic clk;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ftdi_port_arbiter_if bus ();

`ifdef FTDI_ARB_STATS_EN
    logic [15:0] tx_err_cnt, rx_err_cnt, timeout_cnt;
`endif

    ftdi_port_arbiter #(
        .BURST_LEN      (BURST),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
`ifdef FTDI_ARB_STATS_EN
        ,
        .tx_err_cnt_o  (tx_err_cnt),
        .rx_err_cnt_o  (rx_err_cnt),
        .timeout_cnt_o (timeout_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // owner: 0 = port free, 1 = TX transaction open, 2 = RX transaction open
    int m_owner = 0;
    int m_age   = 0;
    int m_last  = 2;
    int m_run   = 0;
    int m_win   = 0;
    logic e_tx_gnt = 0, e_tx_done = 0, e_tx_err = 0;
    logic e_rx_gnt = 0, e_rx_done = 0, e_rx_err = 0;
    logic e_strobe = 0, e_poll = 0, e_timeout = 0;
    logic [7:0] e_fifo_tx_data = 0, e_rx_data = 0;
    int e_tx_err_n = 0, e_rx_err_n = 0, e_timeout_n = 0;

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_age = 0; m_last = 2; m_run = 0;
            {e_tx_gnt, e_tx_done, e_tx_err, e_rx_gnt, e_rx_done, e_rx_err} = '0;
            {e_strobe, e_poll, e_timeout} = '0;
            e_fifo_tx_data = 0; e_rx_data = 0;
            e_tx_err_n = 0; e_rx_err_n = 0; e_timeout_n = 0;
        end else begin
            {e_tx_gnt, e_tx_done, e_tx_err, e_rx_gnt, e_rx_done, e_rx_err} = '0;
            {e_strobe, e_poll, e_timeout} = '0;
            if (m_owner == 0) begin
                if (!bus.fifo_busy_i && (bus.tx_req_i || bus.rx_req_i)) begin
                    if (bus.tx_req_i && bus.rx_req_i)
                        m_win = (m_run > 0 && m_run < BURST) ? m_last : 3 - m_last;
                    else
                        m_win = bus.tx_req_i ? 1 : 2;
                    m_run   = (m_win == m_last && m_run > 0) ? m_run + 1 : 1;
                    m_last  = m_win;
                    m_owner = m_win;
                    m_age   = 0;
                    if (m_win == 1) begin
                        e_tx_gnt = 1; e_strobe = 1; e_fifo_tx_data = bus.tx_data_i;
                    end else begin
                        e_rx_gnt = 1; e_poll = 1;
                    end
                end
            end else if (m_owner == 1) begin
                if (bus.fifo_tx_err_i) begin e_tx_err = 1; m_owner = 0; end
                else if (bus.fifo_tx_ok_i) begin e_tx_done = 1; m_owner = 0; end
                else if (m_age == TMO - 1) begin e_tx_err = 1; e_timeout = 1; m_owner = 0; end
                else m_age++;
            end else begin
                if (bus.fifo_rx_err_i) begin e_rx_err = 1; m_owner = 0; end
                else if (bus.fifo_rx_data_rdy_i) begin
                    e_rx_done = 1; e_rx_data = bus.fifo_rx_data_i; m_owner = 0;
                end
                else if (m_age == TMO - 1) begin e_rx_err = 1; e_timeout = 1; m_owner = 0; end
                else m_age++;
            end
            if (e_tx_err)  e_tx_err_n  = sat16(e_tx_err_n);
            if (e_rx_err)  e_rx_err_n  = sat16(e_rx_err_n);
            if (e_timeout) e_timeout_n = sat16(e_timeout_n);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [24:0] dut_out();
        return {bus.tx_gnt_o, bus.tx_done_o, bus.tx_err_o, bus.rx_gnt_o, bus.rx_done_o,
                bus.rx_data_o, bus.rx_err_o, bus.fifo_tx_data_rdy_o, bus.fifo_tx_data_o,
                bus.fifo_rx_poll_o, bus.timeout_o};
    endfunction

    function automatic logic [24:0] model_out();
        return {e_tx_gnt, e_tx_done, e_tx_err, e_rx_gnt, e_rx_done,
                e_rx_data, e_rx_err, e_strobe, e_fifo_tx_data, e_poll, e_timeout};
    endfunction

    always @(negedge clk) begin
        check("cycle_outputs", 32'(dut_out()), 32'(model_out()));
`ifdef FTDI_ARB_STATS_EN
        check("cycle_tx_err_cnt", 32'(tx_err_cnt), 32'(e_tx_err_n));
        check("cycle_rx_err_cnt", 32'(rx_err_cnt), 32'(e_rx_err_n));
        check("cycle_timeout_cnt", 32'(timeout_cnt), 32'(e_timeout_n));
`endif
    end

    task automatic clear_inputs();
        bus.tx_req_i = 0; bus.tx_data_i = 0; bus.rx_req_i = 0;
        bus.fifo_tx_ok_i = 0; bus.fifo_tx_err_i = 0;
        bus.fifo_rx_data_rdy_i = 0; bus.fifo_rx_err_i = 0; bus.fifo_rx_data_i = 0;
        bus.fifo_busy_i = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [5:0] order;
    int ngrant, n, quiet, range;

    initial begin
        clear_inputs();
        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_out()), 32'h0);
        #1 rst = 1'b0;

        // TX only, completion 10 cycles after the strobe
        do_reset();
        bus.tx_req_i = 1; bus.tx_data_i = 8'hA5;
        @(negedge clk);
        check("tx_gnt_latency", 32'(bus.tx_gnt_o), 32'd1);
        check("tx_strobe_latency", 32'(bus.fifo_tx_data_rdy_o), 32'd1);
        check("tx_fifo_data", 32'(bus.fifo_tx_data_o), 32'hA5);
        bus.tx_data_i = 8'h00;
        repeat (10) @(negedge clk);
        check("tx_data_stable", 32'(bus.fifo_tx_data_o), 32'hA5);
        bus.fifo_tx_ok_i = 1;
        @(negedge clk);
        check("tx_done_after_ok", 32'(bus.tx_done_o), 32'd1);
        bus.fifo_tx_ok_i = 0; bus.tx_req_i = 0;
        @(negedge clk);

        // Both requesters held, immediate completions
        do_reset();
        bus.tx_req_i = 1; bus.rx_req_i = 1; ngrant = 0; order = '0;
        for (int c = 0; c < 60 && ngrant < 6; c++) begin
            @(negedge clk);
            bus.fifo_tx_ok_i       = bus.fifo_tx_data_rdy_o;
            bus.fifo_rx_data_rdy_i = bus.fifo_rx_poll_o;
            if (bus.fifo_tx_data_rdy_o || bus.fifo_rx_poll_o) begin
                order = {bus.fifo_rx_poll_o, order[5:1]};
                ngrant++;
            end
        end
        check("both_grant_count", 32'(ngrant), 32'd6);
        check("both_grant_order", 32'(order), 32'(6'b001100));
        bus.tx_req_i = 0; bus.rx_req_i = 0;
        @(negedge clk);
        clear_inputs();

        // RX data capture and hold, then RX-only stream
        do_reset();
        bus.rx_req_i = 1;
        @(negedge clk);
        check("rx_gnt_latency", 32'(bus.rx_gnt_o), 32'd1);
        bus.fifo_rx_data_i = 8'h3C; bus.fifo_rx_data_rdy_i = 1;
        @(negedge clk);
        check("rx_done", 32'(bus.rx_done_o), 32'd1);
        check("rx_data", 32'(bus.rx_data_o), 32'h3C);
        bus.fifo_rx_data_rdy_i = 0; bus.fifo_rx_data_i = 8'hFF; bus.rx_req_i = 0;
        repeat (3) @(negedge clk);
        check("rx_data_hold", 32'(bus.rx_data_o), 32'h3C);
        bus.rx_req_i = 1; ngrant = 0; order = '0;
        for (int c = 0; c < 40 && ngrant < 3; c++) begin
            @(negedge clk);
            bus.fifo_rx_data_rdy_i = bus.fifo_rx_poll_o;
            if (bus.fifo_tx_data_rdy_o || bus.fifo_rx_poll_o) begin
                order = {bus.fifo_rx_poll_o, order[5:1]};
                ngrant++;
            end
        end
        check("rx_only_order", 32'(order[5:3]), 32'(3'b111));
        bus.rx_req_i = 0;
        @(negedge clk);
        clear_inputs();

        // Watchdog, then the next request is served
        do_reset();
        bus.tx_req_i = 1;
        @(negedge clk);
        check("wd_strobe", 32'(bus.fifo_tx_data_rdy_o), 32'd1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (bus.tx_err_o) break;
        end
        check("wd_err_latency", 32'(n), 32'd16);
        check("wd_timeout_flag", 32'(bus.timeout_o), 32'd1);
        bus.tx_req_i = 0; bus.rx_req_i = 1;
        @(negedge clk);
        check("post_timeout_rx_gnt", 32'(bus.rx_gnt_o), 32'd1);
        bus.rx_req_i = 0; bus.fifo_rx_data_rdy_i = 1;
        @(negedge clk);
        clear_inputs();

        // ok and err together: err wins
        do_reset();
        bus.tx_req_i = 1;
        @(negedge clk);
        bus.fifo_tx_ok_i = 1; bus.fifo_tx_err_i = 1;
        @(negedge clk);
        check("ok_err_err", 32'(bus.tx_err_o), 32'd1);
        check("ok_err_no_done", 32'(bus.tx_done_o), 32'd0);
        clear_inputs();
        @(negedge clk);

        // fifo busy blocks the strobe
        do_reset();
        bus.fifo_busy_i = 1; bus.tx_req_i = 1; n = 0;
        repeat (5) begin
            @(negedge clk);
            n += int'(bus.fifo_tx_data_rdy_o);
        end
        check("busy_no_strobe", 32'(n), 32'd0);
        bus.fifo_busy_i = 0;
        @(negedge clk);
        check("busy_release_strobe", 32'(bus.fifo_tx_data_rdy_o), 32'd1);
        bus.fifo_tx_ok_i = 1; bus.tx_req_i = 0;
        @(negedge clk);
        clear_inputs();

        // asynchronous reset in RX_WAIT
        do_reset();
        bus.rx_req_i = 1;
        @(posedge clk);
        #2;
        check("pre_reset_rx_gnt", 32'(bus.rx_gnt_o), 32'd1);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", 32'(dut_out()), 32'h0);
        bus.rx_req_i = 0;
        @(negedge clk);
        #1 rst = 1'b0;

`ifdef FTDI_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            bus.tx_req_i = 1;
            for (int c = 0; c < 40; c++) begin
                @(negedge clk);
                if (bus.tx_err_o) break;
            end
            bus.tx_req_i = 0;
            @(negedge clk);
        end
        check("stats_timeout_cnt", 32'(timeout_cnt), 32'd3);
        check("stats_tx_err_cnt", 32'(tx_err_cnt), 32'd3);
`endif

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            quiet = ((c / 400) % 2);
            range = (quiet != 0) ? 60 : 5;
            @(negedge clk);
            if (bus.tx_done_o || bus.tx_err_o) begin
                if ($urandom_range(0, 3) != 0) bus.tx_req_i = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.tx_req_i = ~bus.tx_req_i;
            end
            if (bus.rx_done_o || bus.rx_err_o) begin
                if ($urandom_range(0, 3) != 0) bus.rx_req_i = 0;
            end else if ($urandom_range(0, 9) == 0) begin
                bus.rx_req_i = ~bus.rx_req_i;
            end
            bus.tx_data_i          = 8'($urandom);
            bus.fifo_rx_data_i     = 8'($urandom);
            bus.fifo_busy_i        = ($urandom_range(0, 4) == 0);
            bus.fifo_tx_ok_i       = ($urandom_range(0, range) == 0);
            bus.fifo_tx_err_i      = ($urandom_range(0, range * 3) == 0);
            bus.fifo_rx_data_rdy_i = ($urandom_range(0, range) == 0);
            bus.fifo_rx_err_i      = ($urandom_range(0, range * 3) == 0);
        end
        clear_inputs();
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
